// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - register bus transfer sequencer (optional XFER_COUNT_EN transfer counter)
module bus_xfer_ctrl #(
  parameter int NREG = 8,
  parameter int DW   = 8,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SELW-1:0] src_sel,
  input  logic [SELW-1:0] dst_sel,
  input  logic [DW-1:0]   bus_in,
  output logic [NREG-1:0] outflag,
  output logic [NREG-1:0] inflag,
  output logic            done,
  output logic            err,
  output logic [DW-1:0]   last_data
`ifdef XFER_COUNT_EN
  ,
  output logic [15:0]     xfer_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Register count expressed in the select width plus one bit so every index compares cleanly.
  localparam logic [SELW:0] NREG_W = (SELW+1)'(NREG);
  localparam logic [NREG-1:0] ONE  = {{(NREG-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [SELW-1:0]   dst_q, dst_d;
  logic              req_ready_q, req_ready_d;
  logic [NREG-1:0]   outflag_q, outflag_d;
  logic [NREG-1:0]   inflag_q, inflag_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DW-1:0]     last_data_q, last_data_d;
`ifdef XFER_COUNT_EN
  logic [15:0]       xfer_count_q, xfer_count_d;
`endif

  logic              req_ok;

  // A request is legal only when both indices name real registers and differ.
  always_comb begin
    req_ok = (src_sel != dst_sel) &&
             ({1'b0, src_sel} < NREG_W) &&
             ({1'b0, dst_sel} < NREG_W);
  end

  // Next-state and next-output computation; the source strobe is held from DRIVE through LATCH.
  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    req_ready_d = req_ready_q;
    outflag_d   = outflag_q;
    inflag_d    = inflag_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    last_data_d = last_data_q;
`ifdef XFER_COUNT_EN
    xfer_count_d = xfer_count_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        outflag_d   = '0;
        inflag_d    = '0;
        if (req_valid && req_ready_q) begin
          dst_d       = dst_sel;
          req_ready_d = 1'b0;
          if (req_ok) begin
            state_d   = DRIVE;
            outflag_d = ONE << src_sel;
          end else begin
            // Rejected requests skip straight to the completion pulse with no strobes.
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      DRIVE: begin
        state_d  = LATCH;
        inflag_d = ONE << dst_q;
      end
      LATCH: begin
        state_d     = DONE;
        outflag_d   = '0;
        inflag_d    = '0;
        done_d      = 1'b1;
        last_data_d = bus_in;
`ifdef XFER_COUNT_EN
        xfer_count_d = xfer_count_q + 16'd1;
`endif
      end
      DONE: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        outflag_d   = '0;
        inflag_d    = '0;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        outflag_d   = '0;
        inflag_d    = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops every strobe immediately to release the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dst_q       <= '0;
      req_ready_q <= 1'b1;
      outflag_q   <= '0;
      inflag_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_data_q <= '0;
`ifdef XFER_COUNT_EN
      xfer_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      req_ready_q <= req_ready_d;
      outflag_q   <= outflag_d;
      inflag_q    <= inflag_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_data_q <= last_data_d;
`ifdef XFER_COUNT_EN
      xfer_count_q <= xfer_count_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign outflag   = outflag_q;
  assign inflag    = inflag_q;
  assign done      = done_q;
  assign err       = err_q;
  assign last_data = last_data_q;
`ifdef XFER_COUNT_EN
  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - self-checking bench for bus_xfer_ctrl
module tb_bus_xfer_ctrl;

  localparam int NREG = 6;
  localparam int DW   = 8;
  localparam int SELW = 3;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [SELW-1:0] src_sel;
  logic [SELW-1:0] dst_sel;
  logic [DW-1:0]   bus_in;
  logic [NREG-1:0] outflag;
  logic [NREG-1:0] inflag;
  logic            done;
  logic            err;
  logic [DW-1:0]   last_data;
`ifdef XFER_COUNT_EN
  logic [15:0]     xfer_count;
`endif

  bus_xfer_ctrl #(.NREG(NREG), .DW(DW), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .src_sel   (src_sel),
    .dst_sel   (dst_sel),
    .bus_in    (bus_in),
    .outflag   (outflag),
    .inflag    (inflag),
    .done      (done),
    .err       (err),
    .last_data (last_data)
`ifdef XFER_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: drives the bus from the outflag-selected register, loads on inflag.
  logic [DW-1:0] reg_val [NREG];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_val[0] <= 8'h3C;
      reg_val[1] <= 8'h5A;
      reg_val[2] <= 8'hA5;
      reg_val[3] <= 8'h33;
      reg_val[4] <= 8'hC3;
      reg_val[5] <= 8'h0F;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (inflag[i]) reg_val[i] <= bus_in;
    end
  end

  always_comb begin
    bus_in = '0;
    for (int i = 0; i < NREG; i++)
      if (outflag[i]) bus_in = reg_val[i];
  end

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    int s;
    int d;
    bit bad;
  } vec_t;

  exp_t        sbq[$];
  int          acc_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [DW-1:0] exp_last = '0;
  logic [15:0]   exp_cnt = '0;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: scoreboard push on accept, advance to the next falling edge, then monitor.
  task automatic step();
    exp_t e;
    if (req_valid && req_ready) begin
      e.err = !((src_sel != dst_sel) && (int'(src_sel) < NREG) && (int'(dst_sel) < NREG));
      if (!e.err) exp_last = reg_val[src_sel];
      e.data = exp_last;
      sbq.push_back(e);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("invariants", {31'd0, $onehot0(outflag) && $onehot0(inflag) &&
                       ((outflag & inflag) == '0) && (!err || done)}, 32'd1);
    if (done) begin
      chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_err", {31'd0, err}, {31'd0, e.err});
        chk("sb_last_data", {24'd0, last_data}, {24'd0, e.data});
`ifdef XFER_COUNT_EN
        if (!e.err) exp_cnt = exp_cnt + 16'd1;
        chk("sb_xfer_count", {16'd0, xfer_count}, {16'd0, exp_cnt});
`endif
      end
    end
  endtask

  task automatic xfer(input int s, input int d, input bit bad, input bit hold);
    src_sel   = SELW'(s);
    dst_sel   = SELW'(d);
    req_valid = 1'b1;
    chk("ready_before", {31'd0, req_ready}, 32'd1);
    step();
    if (!hold) req_valid = 1'b0;
    src_sel = SELW'($urandom);
    dst_sel = SELW'($urandom);
    if (bad) begin
      chk("bad_done", {31'd0, done}, 32'd1);
      chk("bad_err", {31'd0, err}, 32'd1);
      chk("bad_flags", {20'd0, outflag, inflag}, 32'd0);
      chk("bad_ready", {31'd0, req_ready}, 32'd0);
      step();
    end else begin
      chk("drive_out", {26'd0, outflag}, 32'(1 << s));
      chk("drive_in", {26'd0, inflag}, 32'd0);
      chk("drive_done", {31'd0, done}, 32'd0);
      chk("drive_ready", {31'd0, req_ready}, 32'd0);
      step();
      chk("latch_out", {26'd0, outflag}, 32'(1 << s));
      chk("latch_in", {26'd0, inflag}, 32'(1 << d));
      step();
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_err", {31'd0, err}, 32'd0);
      chk("done_flags", {20'd0, outflag, inflag}, 32'd0);
      chk("done_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    chk("ready_after", {31'd0, req_ready}, 32'd1);
    chk("done_after", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n0;
    tbl[0] = '{s: 2, d: 5, bad: 1'b0};
    tbl[1] = '{s: 3, d: 3, bad: 1'b1};
    tbl[2] = '{s: 0, d: 7, bad: 1'b1};
    tbl[3] = '{s: 0, d: 1, bad: 1'b0};
    tbl[4] = '{s: 5, d: 0, bad: 1'b0};
    tbl[5] = '{s: 6, d: 2, bad: 1'b1};
    tbl[6] = '{s: 1, d: 6, bad: 1'b1};
    tbl[7] = '{s: 4, d: 3, bad: 1'b0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    src_sel   = '0;
    dst_sel   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_flags", {20'd0, outflag, inflag}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_last_data", {24'd0, last_data}, 32'd0);
`ifdef XFER_COUNT_EN
    chk("rst_xfer_count", {16'd0, xfer_count}, 32'd0);
`endif

    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].s, tbl[i].d, tbl[i].bad, 1'b0);
      step();
    end
    chk("reg5_loaded", {24'd0, reg_val[5]}, 32'h0000_00A5);

    // Back-to-back with req_valid held: accepts must be exactly four cycles apart.
    n0 = acc_cyc.size();
    xfer(1, 4, 1'b0, 1'b1);
    xfer(4, 1, 1'b0, 1'b0);
    chk("b2b_accepts", acc_cyc.size(), 32'(n0 + 2));
    if (acc_cyc.size() == n0 + 2)
      chk("b2b_spacing", 32'(acc_cyc[n0+1] - acc_cyc[n0]), 32'd4);
    chk("b2b_sb_drained", sbq.size(), 32'd0);
    step();

`ifdef XFER_COUNT_EN
    force dut.xfer_count_q = 16'hFFFF;
    #1;
    release dut.xfer_count_q;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    xfer(0, 1, 1'b0, 1'b0);
    chk("wrap_xfer_count", {16'd0, xfer_count}, 32'd0);
`endif

    // Asynchronous reset while the destination strobe is high.
    src_sel   = 3'd2;
    dst_sel   = 3'd5;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("pre_rst_inflag", {26'd0, inflag}, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_flags", {20'd0, outflag, inflag}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_last_data", {24'd0, last_data}, 32'd0);
    chk("async_ready", {31'd0, req_ready}, 32'd1);
    sbq.delete();
    exp_last = '0;
    exp_cnt  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    xfer(3, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
